// File: rtl/ft_word_unpacker.sv
// 32-to-16 bit width converter with a small skid buffer, halfword count limit and overflow flag.
// Optional checksum output enabled by defining UNPACK_CHECKSUM_EN.
module ft_word_unpacker #(
  parameter int unsigned DEPTH          = 4,
  parameter bit          LOW_HALF_FIRST = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             sys_clk,
  input  logic             sys_nrst,
  input  logic             sync_clr,
  input  logic             start,
  input  logic [CNT_W-1:0] halfword_total,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_rdy,
  input  logic             fifo_full,
  output logic             fifo_wr_req,
  output logic [15:0]      fifo_wr_data,
  output logic             busy,
  output logic             done,
  output logic             overflow_err,
  output logic [CNT_W-1:0] halfword_cnt
`ifdef UNPACK_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_next;
  logic [31:0]      mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, occ;
  logic [CNT_W-1:0] total_r;
  logic             phase;
  logic             push, wr_en, last_half, pop, start_run, start_zero, sel_high;
  logic [15:0]      half_data;

  assign occ    = wr_ptr - rd_ptr;
  assign busy   = (state == S_RUN);
  assign in_rdy = (state == S_RUN) && (occ < FULL_OCC);

  always_comb begin
    state_next = state;
    push       = in_valid && in_rdy;
    wr_en      = (state == S_RUN) && (occ != '0) && !fifo_full && (halfword_cnt != total_r);
    last_half  = wr_en && ((halfword_cnt + CNT_W'(1)) == total_r);
    // An odd total ends on a first half; the head word is popped with its second half unused.
    pop        = wr_en && (phase || last_half);
    start_run  = (state == S_IDLE) && start && (halfword_total != '0);
    start_zero = (state == S_IDLE) && start && (halfword_total == '0);
    sel_high   = LOW_HALF_FIRST ? phase : !phase;
    half_data  = sel_high ? mem[rd_ptr[AW-1:0]][31:16] : mem[rd_ptr[AW-1:0]][15:0];
    if (start_run) state_next = S_RUN;
    if (last_half) state_next = S_IDLE;
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst)     state <= S_IDLE;
    else if (sync_clr) state <= S_IDLE;
    else               state <= state_next;
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      total_r      <= '0;
      phase        <= 1'b0;
      halfword_cnt <= '0;
      fifo_wr_req  <= 1'b0;
      fifo_wr_data <= '0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else if (sync_clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      total_r      <= '0;
      phase        <= 1'b0;
      halfword_cnt <= '0;
      fifo_wr_req  <= 1'b0;
      fifo_wr_data <= '0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      done        <= last_half || start_zero;
      fifo_wr_req <= wr_en;
      if (wr_en) begin
        fifo_wr_data <= half_data;
        halfword_cnt <= halfword_cnt + CNT_W'(1);
        phase        <= last_half ? 1'b0 : !phase;
      end
      if (start_run || start_zero) begin
        halfword_cnt <= '0;
        total_r      <= halfword_total;
        phase        <= 1'b0;
      end
      if (in_valid && !in_rdy) overflow_err <= 1'b1;
      // Leftover words are discarded once the transfer completes.
      if (last_half) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

`ifdef UNPACK_CHECKSUM_EN
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst)                     checksum <= '0;
    else if (sync_clr)                 checksum <= '0;
    else if (start_run || start_zero)  checksum <= '0;
    else if (wr_en)                    checksum <= checksum + half_data;
  end
`endif

endmodule
